multi_ctrl_sig_sync: RTL and testbench

- Parametrised N-channel synchroniser for asynchronous control inputs (init/continue, start, host strobes) entering the sys_clk_200M domain.
- Per channel:
  - configurable-depth flip-flop synchroniser
  - optional glitch/debounce filter
  - runtime-selectable edge detector (rising/falling/both/off)
  - sticky event flag with acknowledge handshake and overflow detection
- Sits between off-chip/other-domain control sources and the DDR parameter-init and layer-control FSMs.

---
 rtl/multi_ctrl_sig_sync_if.sv | 12 +
 rtl/multi_ctrl_sig_sync.sv | 52 +++++
 tb/tb_multi_ctrl_sig_sync.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/multi_ctrl_sig_sync_if.sv
// multi_ctrl_sig_sync_if: control-input and event-flag bundle for the multi-channel synchroniser
interface multi_ctrl_sig_sync_if #(parameter int N_CH = 4);
  logic [N_CH-1:0]   async_sig_in;
  logic [2*N_CH-1:0] edge_mode;
  logic [N_CH-1:0]   evt_ack;
  logic [N_CH-1:0]   sync_level;
  logic [N_CH-1:0]   sync_pulse;
  logic [N_CH-1:0]   evt_pending;
  logic [N_CH-1:0]   evt_ovf;
  modport master (output async_sig_in, edge_mode, evt_ack, input sync_level, sync_pulse, evt_pending, evt_ovf);
  modport slave (input async_sig_in, edge_mode, evt_ack, output sync_level, sync_pulse, evt_pending, evt_ovf);
endinterface

// File: rtl/multi_ctrl_sig_sync.sv
// multi_ctrl_sig_sync: per-channel synchroniser, debounce filter, edge detector and sticky event flags
module multi_ctrl_sig_sync #(
  parameter int N_CH         = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CNT = 4
) (
  input logic               sys_clk_200M,
  input logic               sys_rst_n,
  multi_ctrl_sig_sync_if.slave bus
);
  localparam int CW = DEBOUNCE_CNT == 0 ? 1 : $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CNT == 0 ? 0 : DEBOUNCE_CNT - 1);
  logic [N_CH-1:0] sync_q [SYNC_STAGES];
  logic [N_CH-1:0] sync_d [SYNC_STAGES];
  logic [CW-1:0]   cnt_q [N_CH];
  logic [CW-1:0]   cnt_d [N_CH];
  logic [N_CH-1:0] synced, filt_q, filt_d, pulse_q, pulse_d, pend_q, pend_d, ovf_q, ovf_d;
  always_comb begin
    sync_d[0] = bus.async_sig_in;
    for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
    synced = sync_q[SYNC_STAGES-1];
    for (int i = 0; i < N_CH; i++) begin
      filt_d[i]  = (DEBOUNCE_CNT == 0 || (synced[i] != filt_q[i] && cnt_q[i] == LAST)) ? synced[i] : filt_q[i];
      cnt_d[i]   = (DEBOUNCE_CNT == 0 || synced[i] == filt_q[i] || cnt_q[i] == LAST) ? '0 : cnt_q[i] + 1'b1;
      pulse_d[i] = (filt_d[i] & ~filt_q[i] & bus.edge_mode[2*i]) | (~filt_d[i] & filt_q[i] & bus.edge_mode[2*i+1]);
    end
    // a fresh event coinciding with ack keeps pending set and clears overflow
    pend_d = pulse_q | (pend_q & ~bus.evt_ack);
    ovf_d  = ~bus.evt_ack & ((pulse_q & pend_q) | ovf_q);
  end
  always_ff @(posedge sys_clk_200M or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
      filt_q  <= '0;
      pulse_q <= '0;
      pend_q  <= '0;
      ovf_q   <= '0;
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= sync_d[k];
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
      filt_q  <= filt_d;
      pulse_q <= pulse_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end
  assign bus.sync_level  = filt_q;
  assign bus.sync_pulse  = pulse_q;
  assign bus.evt_pending = pend_q;
  assign bus.evt_ovf     = ovf_q;
endmodule

// File: tb/tb_multi_ctrl_sig_sync.sv
// tb_multi_ctrl_sig_sync: directed stimulus with a pulse scoreboard for a debounced and a bypass instance
module tb_multi_ctrl_sig_sync;
  logic clk = 0;
  logic rst_a = 1, rst_b = 1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_cmp = 0, n_err = 0;
  typedef struct {int cyc; logic [3:0] pm; logic [3:0] lv;} rec_t;
  rec_t qa[$], qb[$];
  rec_t ra, rb;
  logic [3:0] lvl_a = 0, lvl_b = 0;
  multi_ctrl_sig_sync_if #(.N_CH(4)) bus_a();
  multi_ctrl_sig_sync_if #(.N_CH(4)) bus_b();
  multi_ctrl_sig_sync #(.N_CH(4), .SYNC_STAGES(2), .DEBOUNCE_CNT(4)) u_a (.sys_clk_200M(clk), .sys_rst_n(rst_a), .bus(bus_a));
  multi_ctrl_sig_sync #(.N_CH(4), .SYNC_STAGES(3), .DEBOUNCE_CNT(0)) u_b (.sys_clk_200M(clk), .sys_rst_n(rst_b), .bus(bus_b));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, got, exp, cyc);
    end
  endtask

  // drive a level change and queue the pulse the edge mode should produce
  task automatic step(input int d, input logic [3:0] m, input logic v);
    rec_t r;
    logic [3:0] pm, old;
    logic [7:0] md;
    @(negedge clk);
    md  = d ? bus_b.edge_mode : bus_a.edge_mode;
    old = d ? lvl_b : lvl_a;
    pm  = '0;
    for (int i = 0; i < 4; i++)
      if (m[i] && old[i] != v) pm[i] = v ? md[2*i] : md[2*i+1];
    if (d) begin
      lvl_b = v ? (lvl_b | m) : (lvl_b & ~m);
      bus_b.async_sig_in = lvl_b;
    end else begin
      lvl_a = v ? (lvl_a | m) : (lvl_a & ~m);
      bus_a.async_sig_in = lvl_a;
    end
    r.cyc = cyc + (d ? 4 : 6);
    r.pm  = pm;
    r.lv  = {4{v}};
    if (pm != 0) begin
      if (d) qb.push_back(r);
      else qa.push_back(r);
    end
  endtask

  always @(negedge clk) begin
    if (qa.size() > 0 && qa[0].cyc < cyc) begin
      n_cmp++; n_err++;
      $display("FAIL pulse_a_missed: got none at edge %0d expected %0h", qa[0].cyc, qa[0].pm);
      void'(qa.pop_front());
    end
    if (bus_a.sync_pulse != 0) begin
      n_cmp++;
      if (qa.size() == 0) begin
        n_err++;
        $display("FAIL pulse_a_unexpected: got %0h at edge %0d expected none", bus_a.sync_pulse, cyc);
      end else begin
        ra = qa.pop_front();
        if (ra.cyc != cyc || bus_a.sync_pulse != ra.pm || (bus_a.sync_level & ra.pm) != (ra.lv & ra.pm)) begin
          n_err++;
          $display("FAIL pulse_a: got pulse %0h level %0h at edge %0d expected pulse %0h level %0h at edge %0d",
                   bus_a.sync_pulse, bus_a.sync_level, cyc, ra.pm, ra.lv & ra.pm, ra.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (qb.size() > 0 && qb[0].cyc < cyc) begin
      n_cmp++; n_err++;
      $display("FAIL pulse_b_missed: got none at edge %0d expected %0h", qb[0].cyc, qb[0].pm);
      void'(qb.pop_front());
    end
    if (bus_b.sync_pulse != 0) begin
      n_cmp++;
      if (qb.size() == 0) begin
        n_err++;
        $display("FAIL pulse_b_unexpected: got %0h at edge %0d expected none", bus_b.sync_pulse, cyc);
      end else begin
        rb = qb.pop_front();
        if (rb.cyc != cyc || bus_b.sync_pulse != rb.pm || (bus_b.sync_level & rb.pm) != (rb.lv & rb.pm)) begin
          n_err++;
          $display("FAIL pulse_b: got pulse %0h level %0h at edge %0d expected pulse %0h level %0h at edge %0d",
                   bus_b.sync_pulse, bus_b.sync_level, cyc, rb.pm, rb.lv & rb.pm, rb.cyc);
        end
      end
    end
  end

  initial begin
    rec_t r;
    logic [1:0] modes [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    bus_a.async_sig_in = 0; bus_a.edge_mode = {2'b11, 2'b01, 2'b00, 2'b01}; bus_a.evt_ack = 0;
    bus_b.async_sig_in = 0; bus_b.edge_mode = 8'hFF; bus_b.evt_ack = 0;
    #1 rst_a = 0; rst_b = 0;
    #1;
    chk("reset_level", bus_a.sync_level, 0);
    chk("reset_pulse", bus_a.sync_pulse, 0);
    chk("reset_pending", bus_a.evt_pending, 0);
    chk("reset_ovf", bus_a.evt_ovf, 0);
    @(negedge clk) rst_a = 1; rst_b = 1;
    // rising step on channel 0
    step(0, 4'b0001, 1);
    repeat (7) @(negedge clk);
    chk("rise_pending", bus_a.evt_pending, 4'b0001);
    chk("rise_level", bus_a.sync_level, 4'b0001);
    bus_a.evt_ack = 4'b0001;
    @(negedge clk) bus_a.evt_ack = 0;
    chk("rise_ack", bus_a.evt_pending, 0);
    // 3-cycle glitch rejected, 4-cycle pulse accepted
    bus_a.async_sig_in[2] = 1;
    repeat (3) @(negedge clk);
    bus_a.async_sig_in[2] = 0;
    repeat (10) @(negedge clk);
    chk("glitch_level", bus_a.sync_level, 4'b0001);
    chk("glitch_pending", bus_a.evt_pending, 0);
    step(0, 4'b0100, 1);
    repeat (3) @(negedge clk);
    step(0, 4'b0100, 0);
    repeat (10) @(negedge clk);
    chk("accept_pending", bus_a.evt_pending, 4'b0100);
    chk("accept_level", bus_a.sync_level, 4'b0001);
    bus_a.evt_ack = 4'hF;
    @(negedge clk) bus_a.evt_ack = 0;
    chk("accept_ack", bus_a.evt_pending, 0);
    // mode sweep on channel 1
    for (int m = 0; m < 4; m++) begin
      bus_a.edge_mode[3:2] = modes[m];
      step(0, 4'b0010, 1);
      repeat (9) @(negedge clk);
      chk("sweep_level_high", bus_a.sync_level, 4'b0011);
      step(0, 4'b0010, 0);
      repeat (9) @(negedge clk);
      chk("sweep_level_low", bus_a.sync_level, 4'b0001);
    end
    chk("sweep_pending", bus_a.evt_pending, 4'b0010);
    chk("sweep_ovf", bus_a.evt_ovf, 4'b0010);
    bus_a.evt_ack = 4'hF;
    @(negedge clk) bus_a.evt_ack = 0;
    chk("sweep_ack_ovf", bus_a.evt_ovf, 0);
    // overflow, ack, and ack coinciding with a new pulse on channel 3
    step(0, 4'b1000, 1); repeat (9) @(negedge clk);
    step(0, 4'b1000, 0); repeat (9) @(negedge clk);
    chk("ovf_pending", bus_a.evt_pending, 4'b1000);
    chk("ovf_flag", bus_a.evt_ovf, 4'b1000);
    bus_a.evt_ack = 4'b1000;
    @(negedge clk) bus_a.evt_ack = 0;
    chk("ovf_ack_pending", bus_a.evt_pending, 0);
    chk("ovf_ack_flag", bus_a.evt_ovf, 0);
    step(0, 4'b1000, 1); repeat (9) @(negedge clk);
    step(0, 4'b1000, 0); repeat (9) @(negedge clk);
    chk("ovf2_flag", bus_a.evt_ovf, 4'b1000);
    step(0, 4'b1000, 1);
    repeat (6) @(negedge clk);
    bus_a.evt_ack = 4'b1000;
    @(negedge clk) bus_a.evt_ack = 0;
    chk("coincide_pending", bus_a.evt_pending, 4'b1000);
    chk("coincide_ovf", bus_a.evt_ovf, 0);
    // asynchronous reset mid-debounce with an event pending
    repeat (4) @(negedge clk);
    bus_a.async_sig_in[2] = 1;
    repeat (3) @(negedge clk);
    #2 rst_a = 0;
    #1;
    chk("areset_level", bus_a.sync_level, 0);
    chk("areset_pulse", bus_a.sync_pulse, 0);
    chk("areset_pending", bus_a.evt_pending, 0);
    chk("areset_ovf", bus_a.evt_ovf, 0);
    @(negedge clk) rst_a = 1;
    r.cyc = cyc + 6; r.pm = 4'b1101; r.lv = 4'hF;
    qa.push_back(r);
    lvl_a = 4'b1101;
    repeat (8) @(negedge clk);
    chk("release_pending", bus_a.evt_pending, 4'b1101);
    chk("release_level", bus_a.sync_level, 4'b1101);
    // bypass instance: 3-stage sync, no filter
    step(1, 4'b0001, 1); repeat (6) @(negedge clk);
    step(1, 4'b0001, 0); repeat (6) @(negedge clk);
    step(1, 4'hF, 1); repeat (6) @(negedge clk);
    chk("bypass_level", bus_b.sync_level, 4'hF);
    chk("bypass_pending", bus_b.evt_pending, 4'hF);
    chk("bypass_ovf", bus_b.evt_ovf, 4'b0001);
    step(1, 4'hF, 0); repeat (6) @(negedge clk);
    chk("bypass_level_low", bus_b.sync_level, 0);
    repeat (10) @(negedge clk);
    chk("queue_a_drained", qa.size(), 0);
    chk("queue_b_drained", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
